// File: rtl/life_pkg.sv
// Shared defaults and state encoding for the Game-of-Life generation scheduler.
package life_pkg;

  localparam int W_LOG2_DEF = 3;
  localparam int H_LOG2_DEF = 3;
  localparam int SIZE_DEF   = 1 << (W_LOG2_DEF + H_LOG2_DEF);

  localparam logic [63:0] SEED_DEF = 64'h0A30_1548_1148_1148;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

endpackage

// File: rtl/life_next_cell.sv
// Combinational next-state of one cell: neighbour gather, 4-bit count and the life rule.
module life_next_cell
  import life_pkg::*;
#(
  parameter int W_LOG2 = W_LOG2_DEF,
  parameter int H_LOG2 = H_LOG2_DEF,
  parameter int WRAP   = 0,
  localparam int N     = W_LOG2 + H_LOG2,
  localparam int SIZE  = 1 << N
) (
  input  logic [SIZE-1:0] board,
  input  logic [N-1:0]    idx,
  output logic            next_cell
);

  localparam int W = 1 << W_LOG2;
  localparam int H = 1 << H_LOG2;

  logic [3:0] count;
  int         r;
  int         c;

  always_comb begin
    count = '0;
    r     = 0;
    c     = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(idx[N-1:W_LOG2]) + dr;
        c = int'(idx[W_LOG2-1:0]) + dc;
        // Truncating r/c to their field widths gives the toroidal wrap for free.
        if (!(dr == 0 && dc == 0) &&
            (WRAP != 0 || (r >= 0 && r < H && c >= 0 && c < W)))
          count = count + 4'(board[{r[H_LOG2-1:0], c[W_LOG2-1:0]}]);
      end
    end
    next_cell = (count == 4'd3) || (board[idx] && count == 4'd2);
  end

endmodule

// File: rtl/life_gen_scheduler.sv
// Owns the committed board; paces generations from vsync or step, scans serially into a
// shadow board and commits it in one cycle so the renderer never sees a partial update.
module life_gen_scheduler
  import life_pkg::*;
#(
  parameter int W_LOG2         = W_LOG2_DEF,
  parameter int H_LOG2         = H_LOG2_DEF,
  parameter int FRAMES_PER_GEN = 60,
  parameter int WRAP           = 0,
  parameter logic [(1 << (W_LOG2 + H_LOG2))-1:0] SEED = SEED_DEF,
  localparam int N             = W_LOG2 + H_LOG2,
  localparam int SIZE          = 1 << N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vsync,
  input  logic            run,
  input  logic            step,
  input  logic            clear,
  input  logic            reseed,
  input  logic [N-1:0]    rd_idx,
  output logic            rd_cell,
  output logic [SIZE-1:0] board,
  output logic            busy,
  output logic            gen_done,
  output logic [15:0]     gen_count
);

  localparam logic [15:0] FCNT_LAST = 16'(FRAMES_PER_GEN - 1);

  state_t          state;
  logic            vsync_q;
  logic [15:0]     fcnt;
  logic [N-1:0]    idx;
  logic [SIZE-1:0] next_board;
  logic            next_cell;
  logic            tick;
  logic            frame_ok;
  logic            trigger;

  assign tick     = vsync & ~vsync_q;
  assign frame_ok = tick && run && (state == IDLE);
  assign trigger  = frame_ok && (fcnt == FCNT_LAST);
  assign rd_cell  = board[rd_idx];

  life_next_cell #(
    .W_LOG2 (W_LOG2),
    .H_LOG2 (H_LOG2),
    .WRAP   (WRAP)
  ) u_next_cell (
    .board     (board),
    .idx       (idx),
    .next_cell (next_cell)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      fcnt       <= '0;
      idx        <= '0;
      next_board <= '0;
      board      <= SEED;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
      gen_count  <= '0;
    end else begin
      vsync_q  <= vsync;
      gen_done <= 1'b0;
      if (frame_ok)
        fcnt <= trigger ? 16'd0 : fcnt + 16'd1;

      // clear/reseed win over everything and abort any scan without committing.
      if (clear) begin
        board <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end else if (reseed) begin
        board <= SEED;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (step || trigger) begin
              idx   <= '0;
              state <= SCAN;
              busy  <= 1'b1;
            end
          end
          SCAN: begin
            next_board[idx] <= next_cell;
            if (idx == '1) state <= COMMIT;
            else           idx   <= idx + 1'b1;
          end
          COMMIT: begin
            board     <= next_board;
            gen_count <= gen_count + 16'd1;
            gen_done  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/life_gen_scheduler.md
# life_gen_scheduler

Generation scheduler for the Game-of-Life board. It owns the board state and sequences one generation update every `FRAMES_PER_GEN` frames, or on a manual step. Each update walks the board serially, one cell per clock, into a shadow board, then commits it atomically so the VGA renderer never sees a half-updated board. It sits between the VGA sync generator (frame timing) and the pixel colour logic (cell lookup), and replaces a vsync-clocked update process with a single-clock controller.

## Interface
Parameters:
- `W_LOG2`, default 3: log2 of board width in cells.
- `H_LOG2`, default 3: log2 of board height in cells.
- `FRAMES_PER_GEN`, default 60: frames per automatic generation. Legal range 1..65535.
- `WRAP`, default 0: 0 means cells outside the board are dead; 1 means toroidal edges.
- `SEED`, default 64'h0A30_1548_1148_1148: board loaded at reset and on `reseed`. Bit i is cell i, with i = row*W + col.

Ports (N = W_LOG2+H_LOG2, SIZE = 2^N):
- `clk`, input, 1: system/pixel clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `vsync`, input, 1: VGA vsync level, synchronous to `clk`.
- `run`, input, 1: level; enables automatic generations.
- `step`, input, 1: one-cycle pulse; requests one generation.
- `clear`, input, 1: one-cycle pulse; kills all cells.
- `reseed`, input, 1: one-cycle pulse; loads `SEED`.
- `rd_idx`, input, N: cell index requested by the renderer.
- `rd_cell`, output, 1: combinational `board[rd_idx]`.
- `board`, output, SIZE: committed board.
- `busy`, output, 1: high while a generation is in progress.
- `gen_done`, output, 1: one-cycle pulse in the cycle after commit.
- `gen_count`, output, 16: count of committed generations.

## Operation
- Frame tick: `vsync` is registered. `tick` is high for one cycle when the input is 1 and the registered copy is 0 (rising edge).
- Frame counter `fcnt`, 16 bits:
  - On `tick` with `run`=1 and state IDLE: if `fcnt == FRAMES_PER_GEN-1`, set `fcnt` to 0 and trigger; otherwise increment `fcnt`.
  - `fcnt` holds while `run`=0 or while the block is not IDLE.
- States:
  - IDLE: `busy`=0. On a trigger or `step`, set `idx`=0 and go to SCAN.
  - SCAN: `busy`=1. Write `next[idx]` = rule(`board`, `idx`). When `idx == SIZE-1`, go to COMMIT; otherwise increment `idx`.
  - COMMIT: `busy`=1. `board` <= `next`; `gen_count` +1, wrapping 16'hFFFF to 0; return to IDLE.
- Rule (evaluated against the committed `board`, which is unchanged during SCAN):
  - Neighbour count is 4-bit unsigned, range 0..8.
  - Live cell survives on a count of 2 or 3; dead cell is born on a count of 3; all other cases give a dead cell.
- Edges: WRAP=0 treats out-of-range neighbours as 0. WRAP=1 wraps row and column modulo W and H (natural N-bit overflow).
- Command priority within one cycle, in any state: `clear` > `reseed` > `step` > frame trigger.
  - `clear` or `reseed` in SCAN aborts the scan: `next` is discarded, there is no commit, `gen_count` and `gen_done` are unchanged, and the state becomes IDLE.
  - `clear`/`reseed` update `board` in the cycle after assertion.
  - `step` while `busy`=1 is dropped, not queued. A frame trigger that coincides with `step` in IDLE starts a single generation.
- Reset values: `board`=`SEED`, `next`=0, `fcnt`=0, `gen_count`=0, state IDLE, `busy`=0, `gen_done`=0, vsync register 0.

## Timing
- Latency from trigger or `step` (cycle T) to updated `board`: `busy`=1 from T+1. SCAN occupies T+1..T+SIZE and COMMIT is T+SIZE+1. The new `board` and `gen_done`=1 are visible at T+SIZE+2, which is 66 cycles for an 8x8 board.
- `board` changes only at COMMIT, clear or reseed, each a single-cycle atomic update.
- `rd_cell` has zero-cycle latency and is valid for any `rd_idx`.
- Reset assertion mid-SCAN takes effect immediately (asynchronous), with no partial commit.
- SIZE+2 cycles is far shorter than one frame, so a trigger can never overlap an active generation.

## Structure
- Package `life_pkg` holds `W_LOG2`/`H_LOG2` defaults, `SIZE`, the state enum (IDLE, SCAN, COMMIT) and the default `SEED`.
- Sub-module `life_next_cell` (combinational) takes the board, `idx` and `WRAP`, and produces the next-state bit. It holds the neighbour gather, the 4-bit count and the rule.
- Top level holds the frame counter, FSM, shadow board and command priority.

## Test plan
- Blinker: `SEED` = cells {9,10,11}, issue `step` → after 66 cycles `board` = {2,10,18}, `gen_done` pulses once, `gen_count`=1. A second `step` restores {9,10,11}.
- Block still life {0,1,8,9} with WRAP=0, `run`=1, FRAMES_PER_GEN=2 → after 4 vsync rises `gen_count`=2 and `board` unchanged.
- Corner with WRAP=1: cells {0,7,56} → cell 63 is born (3 neighbours); with WRAP=0 it stays dead.
- Abort: `step`, then `clear` at SCAN idx=20 → `board`=0 the next cycle, `busy`=0, `gen_count` unchanged, no `gen_done` pulse.
- Priority: `clear` and `reseed` in the same cycle → `board`=0. `step` while `busy`=1 → exactly one generation occurs.
- Frame pacing: `run`=1, FRAMES_PER_GEN=60, 120 vsync rises → exactly 2 `gen_done` pulses. With `run`=0 → `fcnt` holds and no pulses occur.
